// File: rtl/display7_scan.sv
// display7_scan
// Multiplexed N-digit seven-segment display driver. One nibble and one decimal
// point per digit are snapshotted once per refresh frame and scanned onto a
// shared active-low segment bus. Each digit slot starts with a dead-time
// interval to suppress ghosting.
//
// Ports:
//   iClk   in   1          system clock, rising edge
//   iRst   in   1          synchronous active-high reset
//   iData  in   4*DIGITS   digit k value in iData[4k+3:4k]
//   iDp    in   DIGITS     decimal point request per digit, 1 = lit
//   iLzb   in   1          1 = leading-zero blanking enabled
//   oSeg   out  7          segments a..g on oSeg[0]..oSeg[6], active-low
//   oDp    out  1          decimal point, active-low
//   oAn    out  DIGITS     digit select, oAn[k]=0 drives digit k
module display7_scan #(
    parameter int DIGITS   = 8,
    parameter int DIV      = 100000,
    parameter int BLANK    = 4,
    parameter int HEX_MODE = 0
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic [4*DIGITS-1:0]   iData,
    input  logic [DIGITS-1:0]     iDp,
    input  logic                  iLzb,
    output logic [6:0]            oSeg,
    output logic                  oDp,
    output logic [DIGITS-1:0]     oAn
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    // Scan state
    logic [CW-1:0]          r_cnt;
    logic [IW-1:0]          r_idx;

    // Frame snapshot
    logic [4*DIGITS-1:0]    r_data;
    logic [DIGITS-1:0]      r_dp_snap;
    logic                   r_lzb;

    // Registered pin drivers
    logic [6:0]             r_seg;
    logic                   r_dp;
    logic [DIGITS-1:0]      r_an;

    logic [3:0]             w_nib [DIGITS];
    logic [DIGITS:0]        w_upper_zero;
    logic [DIGITS-1:0]      w_lz_blank;
    logic [DIGITS-1:0]      w_an_sel;
    logic [3:0]             w_cur_nib;
    logic                   w_cur_dp;
    logic                   w_cur_blank;
    logic [6:0]             w_dec;
    logic                   w_dead;
    logic                   w_load;
    logic                   w_slot_end;

    // w_upper_zero[k] is 1 when nibbles k..DIGITS-1 are all zero.
    assign w_upper_zero[DIGITS] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_nib[gi]        = r_data[4*gi +: 4];
            assign w_upper_zero[gi] = (w_nib[gi] == 4'd0) && w_upper_zero[gi+1];
            assign w_an_sel[gi]     = (r_idx == IW'(gi));
            if (gi == 0) begin : g_lsd
                // The least significant digit always shows, even when zero.
                assign w_lz_blank[gi] = 1'b0;
            end else begin : g_upper
                assign w_lz_blank[gi] = r_lzb && w_upper_zero[gi];
            end
        end
    endgenerate

    // One-hot mux of the active digit's nibble, point and blank flag.
    always_comb begin
        w_cur_nib   = 4'd0;
        w_cur_dp    = 1'b0;
        w_cur_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_an_sel[k]) begin
                w_cur_nib   = w_nib[k];
                w_cur_dp    = r_dp_snap[k];
                w_cur_blank = w_lz_blank[k];
            end
        end
    end

    // Active-low decode, oSeg[6:0] = g..a
    always_comb begin
        w_dec = 7'b1111111;
        case (w_cur_nib)
            4'h0: w_dec = 7'b1000000;
            4'h1: w_dec = 7'b1111001;
            4'h2: w_dec = 7'b0100100;
            4'h3: w_dec = 7'b0110000;
            4'h4: w_dec = 7'b0011001;
            4'h5: w_dec = 7'b0010010;
            4'h6: w_dec = 7'b0000010;
            4'h7: w_dec = 7'b1111000;
            4'h8: w_dec = 7'b0000000;
            4'h9: w_dec = 7'b0010000;
            4'hA: w_dec = (HEX_MODE != 0) ? 7'b0001000 : 7'b1111111;
            4'hB: w_dec = (HEX_MODE != 0) ? 7'b0000011 : 7'b1111111;
            4'hC: w_dec = (HEX_MODE != 0) ? 7'b1000110 : 7'b1111111;
            4'hD: w_dec = (HEX_MODE != 0) ? 7'b0100001 : 7'b1111111;
            4'hE: w_dec = (HEX_MODE != 0) ? 7'b0000110 : 7'b1111111;
            4'hF: w_dec = (HEX_MODE != 0) ? 7'b0001110 : 7'b1111111;
            default: w_dec = 7'b1111111;
        endcase
    end

    assign w_dead     = (r_cnt < CNT_BLANK);
    assign w_slot_end = (r_cnt == CNT_LAST);
    // Snapshot loads at the very start of a frame; this cycle is always in
    // dead time, so no digit is ever shown from a half-updated snapshot.
    assign w_load     = (r_cnt == '0) && (r_idx == '0);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_data    <= '0;
            r_dp_snap <= '0;
            r_lzb     <= 1'b0;
            r_seg     <= 7'b1111111;
            r_dp      <= 1'b1;
            r_an      <= '1;
        end else begin
            if (w_load) begin
                r_data    <= iData;
                r_dp_snap <= iDp;
                r_lzb     <= iLzb;
            end

            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Outputs reflect the pre-edge cnt/idx/snapshot.
            if (w_dead) begin
                r_seg <= 7'b1111111;
                r_dp  <= 1'b1;
                r_an  <= '1;
            end else begin
                r_seg <= w_cur_blank ? 7'b1111111 : w_dec;
                r_dp  <= ~w_cur_dp;
                r_an  <= ~w_an_sel;
            end
        end
    end

    assign oSeg = r_seg;
    assign oDp  = r_dp;
    assign oAn  = r_an;

endmodule

// File: tb/tb_display7_scan.sv
module tb_display7_scan;

    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int BLANK  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  dp;
    logic        lzb;

    logic [6:0]  seg;
    logic        odp;
    logic [3:0]  an;
    logic [6:0]  hseg;
    logic        hdp;
    logic [3:0]  han;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    display7_scan #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK), .HEX_MODE(0)) u_dut (
        .iClk(clk), .iRst(rst), .iData(data), .iDp(dp), .iLzb(lzb),
        .oSeg(seg), .oDp(odp), .oAn(an)
    );

    display7_scan #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK), .HEX_MODE(1)) u_hex (
        .iClk(clk), .iRst(rst), .iData(data), .iDp(dp), .iLzb(lzb),
        .oSeg(hseg), .oDp(hdp), .oAn(han)
    );

    // Advance one clock and sample away from the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        data = 16'h1234;
        dp   = 4'b0100;
        lzb  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({an, seg, odp} !== {4'b1111, 7'b1111111, 1'b1}) begin
                failures++;
                $display("FAIL reset cyc=%0d got an=%b seg=%b dp=%b want an=1111 seg=1111111 dp=1",
                         i, an, seg, odp);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_scan;
        logic [6:0] seg_tbl [4];
        logic       dp_tbl  [4];
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        seg_tbl[0] = 7'b0011001; dp_tbl[0] = 1'b1;
        seg_tbl[1] = 7'b0110000; dp_tbl[1] = 1'b1;
        seg_tbl[2] = 7'b0100100; dp_tbl[2] = 1'b0;
        seg_tbl[3] = 7'b1111001; dp_tbl[3] = 1'b1;
        data = 16'h1234; dp = 4'b0100; lzb = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int t = 0; t < 32; t++) begin
                tick();
                exp_an  = (t % 8 < 2) ? 4'b1111    : ~(4'b0001 << (t / 8));
                exp_seg = (t % 8 < 2) ? 7'b1111111 : seg_tbl[t / 8];
                exp_dp  = (t % 8 < 2) ? 1'b1       : dp_tbl[t / 8];
                checks++;
                if ({an, seg, odp} !== {exp_an, exp_seg, exp_dp}) begin
                    failures++;
                    $display("FAIL basic_scan frame=%0d t=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                             f, t, an, seg, odp, exp_an, exp_seg, exp_dp);
                end
            end
        end
    endtask

    task automatic test_tearing;
        logic [6:0] seg_tbl [8];
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        // frame 0: 4,3,2,1 ; frame 1: 8,7,6,5
        seg_tbl[0] = 7'b0011001; seg_tbl[1] = 7'b0110000;
        seg_tbl[2] = 7'b0100100; seg_tbl[3] = 7'b1111001;
        seg_tbl[4] = 7'b0000000; seg_tbl[5] = 7'b1111000;
        seg_tbl[6] = 7'b0000010; seg_tbl[7] = 7'b0010010;
        data = 16'h1234; dp = 4'b0100; lzb = 1'b0;
        for (int t = 0; t < 64; t++) begin
            tick();
            exp_an  = (t % 8 < 2) ? 4'b1111    : ~(4'b0001 << ((t / 8) % 4));
            exp_seg = (t % 8 < 2) ? 7'b1111111 : seg_tbl[t / 8];
            exp_dp  = (t % 8 < 2) ? 1'b1       : (((t / 8) % 4) != 2);
            checks++;
            if ({an, seg, odp} !== {exp_an, exp_seg, exp_dp}) begin
                failures++;
                $display("FAIL tearing t=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         t, an, seg, odp, exp_an, exp_seg, exp_dp);
            end
            if (t == 12) data = 16'h5678;   // mid-window of digit 1
        end
    endtask

    task automatic test_lzb;
        logic [6:0] seg_tbl [8];
        logic       dp_tbl  [8];
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        // frame 0: 0050 -> 0,5,blank,blank ; frame 1: 0000 -> 0,blank,blank,blank(dp lit)
        seg_tbl[0] = 7'b1000000; seg_tbl[1] = 7'b0010010;
        seg_tbl[2] = 7'b1111111; seg_tbl[3] = 7'b1111111;
        seg_tbl[4] = 7'b1000000; seg_tbl[5] = 7'b1111111;
        seg_tbl[6] = 7'b1111111; seg_tbl[7] = 7'b1111111;
        for (int i = 0; i < 8; i++) dp_tbl[i] = 1'b1;
        dp_tbl[7] = 1'b0;
        data = 16'h0050; dp = 4'b0000; lzb = 1'b1;
        for (int t = 0; t < 64; t++) begin
            if (t == 0) begin
                data = 16'h0050; dp = 4'b0000;
            end
            if (t == 32) begin
                data = 16'h0000; dp = 4'b1000;
            end
            tick();
            exp_an  = (t % 8 < 2) ? 4'b1111    : ~(4'b0001 << ((t / 8) % 4));
            exp_seg = (t % 8 < 2) ? 7'b1111111 : seg_tbl[t / 8];
            exp_dp  = (t % 8 < 2) ? 1'b1       : dp_tbl[t / 8];
            checks++;
            if ({an, seg, odp} !== {exp_an, exp_seg, exp_dp}) begin
                failures++;
                $display("FAIL lzb t=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         t, an, seg, odp, exp_an, exp_seg, exp_dp);
            end
        end
    endtask

    task automatic test_hex;
        logic [6:0] seg_tbl [4];
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic [6:0] exp_dec;
        seg_tbl[0] = 7'b0001110;  // F
        seg_tbl[1] = 7'b1000110;  // C
        seg_tbl[2] = 7'b0000011;  // b
        seg_tbl[3] = 7'b0001000;  // A
        data = 16'hABCF; dp = 4'b0000; lzb = 1'b0;
        for (int t = 0; t < 32; t++) begin
            tick();
            exp_an  = (t % 8 < 2) ? 4'b1111 : ~(4'b0001 << (t / 8));
            exp_seg = (t % 8 < 2) ? 7'b1111111 : seg_tbl[t / 8];
            exp_dec = 7'b1111111;
            checks++;
            if ({han, hseg, hdp} !== {exp_an, exp_seg, 1'b1}) begin
                failures++;
                $display("FAIL hex_mode1 t=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=1",
                         t, han, hseg, hdp, exp_an, exp_seg);
            end
            checks++;
            if ({an, seg, odp} !== {exp_an, exp_dec, 1'b1}) begin
                failures++;
                $display("FAIL hex_mode0 t=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=1",
                         t, an, seg, odp, exp_an, exp_dec);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [6:0] seg_tbl [8];
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        // old frame 1234: 4,3,2,1 ; new frame 9087: 7,8,0,9
        seg_tbl[0] = 7'b0011001; seg_tbl[1] = 7'b0110000;
        seg_tbl[2] = 7'b0100100; seg_tbl[3] = 7'b1111001;
        seg_tbl[4] = 7'b1111000; seg_tbl[5] = 7'b0000000;
        seg_tbl[6] = 7'b1000000; seg_tbl[7] = 7'b0010000;
        data = 16'h1234; dp = 4'b0000; lzb = 1'b0;
        for (int t = 0; t < 21; t++) begin
            tick();
            exp_an  = (t % 8 < 2) ? 4'b1111    : ~(4'b0001 << (t / 8));
            exp_seg = (t % 8 < 2) ? 7'b1111111 : seg_tbl[t / 8];
            checks++;
            if ({an, seg, odp} !== {exp_an, exp_seg, 1'b1}) begin
                failures++;
                $display("FAIL reset_mid_pre t=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=1",
                         t, an, seg, odp, exp_an, exp_seg);
            end
        end
        data = 16'h9087;
        rst  = 1'b1;
        tick();
        checks++;
        if ({an, seg, odp} !== {4'b1111, 7'b1111111, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid_off got an=%b seg=%b dp=%b want an=1111 seg=1111111 dp=1",
                     an, seg, odp);
        end
        rst = 1'b0;
        for (int t = 0; t < 32; t++) begin
            tick();
            exp_an  = (t % 8 < 2) ? 4'b1111    : ~(4'b0001 << (t / 8));
            exp_seg = (t % 8 < 2) ? 7'b1111111 : seg_tbl[4 + t / 8];
            checks++;
            if ({an, seg, odp} !== {exp_an, exp_seg, 1'b1}) begin
                failures++;
                $display("FAIL reset_mid_post t=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=1",
                         t, an, seg, odp, exp_an, exp_seg);
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        data = 16'h0000;
        dp   = 4'b0000;
        lzb  = 1'b0;
        test_reset();
        test_basic_scan();
        test_tearing();
        test_lzb();
        test_hex();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display7_scan.md
# display7_scan

Multiplexed N-digit seven-segment display driver. Takes one packed nibble per digit plus per-digit decimal points, snapshots them once per refresh frame, and time-multiplexes the digits onto one shared active-low segment bus with active-low digit (anode) selects. Decode supports decimal mode (10–15 blank) or hex mode, with optional leading-zero blanking and a dead-time interval between digits to suppress ghosting. Sits between the board-level datapath and the physical display pins.

## Interface
- DIGITS, 8, number of digits scanned; 1 to 16.
- DIV, 100000, clock cycles per digit slot; at least 2.
- BLANK, 4, dead-time cycles at the start of each slot; 1 to DIV-1.
- HEX_MODE, 0, 0 blanks nibbles 10–15; 1 shows them as A b C d E F.

Ports:
- iClk  in  1  system clock; all logic on the rising edge.
- iRst  in  1  synchronous, active-high reset.
- iData  in  4*DIGITS  digit k value in iData[4k+3:4k]; digit 0 is least significant.
- iDp  in  DIGITS  decimal point request per digit, 1 = lit.
- iLzb  in  1  1 = leading-zero blanking enabled.
- oSeg  out  7  segments a..g on oSeg[0]..oSeg[6], active-low.
- oDp  out  1  decimal point, active-low.
- oAn  out  DIGITS  digit select, oAn[k]=0 drives digit k.

## Operation
- Slot counter cnt counts 0..DIV-1 and wraps to 0. Digit index idx advances on the cycle cnt==DIV-1, wrapping DIGITS-1 to 0. Scan order is 0,1,...,DIGITS-1.
- Snapshot: whenever cnt==0 and idx==0, iData, iDp and iLzb are captured into internal registers. All decode uses the snapshot only. Input changes mid-frame never appear until the next frame.
- Decode of the snapshot nibble for digit idx:
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000 (oSeg[6:0]).
  - 10–15 with HEX_MODE=0 → 1111111.
  - With HEX_MODE=1: A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110.
- Leading-zero blanking, when snapshot iLzb=1: digit k>0 shows oSeg=1111111 if nibbles k..DIGITS-1 are all zero. Digit 0 is never blanked. The decimal point is unaffected by blanking.
- Dead time: while cnt<BLANK, oAn is all ones and oSeg/oDp are all ones. Otherwise oAn has only bit idx low, and oSeg/oDp carry digit idx.

## Timing
- oSeg, oDp and oAn are registered. They reflect cnt, idx and the snapshot as they stood before the same clock edge, i.e. one cycle of latency.
- Reset (sampled on the rising edge while iRst=1) sets cnt=0, idx=0, snapshot=0, oAn=all ones, oSeg=1111111, oDp=1.
- The first cycle after reset has cnt=0 and idx=0, so the snapshot loads immediately.
- Per slot: BLANK cycles with all digits off, then DIV-BLANK cycles with exactly one digit on.
- Frame period is DIGITS*DIV cycles.
- The snapshot-load cycle always falls inside dead time (BLANK≥1). No segment pattern is ever driven from a partially updated snapshot.
- Reset asserted mid-frame: outputs go off on the next edge and the scan restarts at digit 0.
- DIGITS=1: idx stays 0, and the snapshot reloads every DIV cycles.

## Test plan
Bench parameters: DIGITS=4, DIV=8, BLANK=2, HEX_MODE=0.
- **Reset.** Hold iRst=1 for 3 cycles → oAn=1111, oSeg=1111111, oDp=1 on every cycle.
- **Basic scan.** Release reset with iData=16'h1234, iDp=4'b0100, iLzb=0. Required repeating sequence, each line a slot:
  - 2 cycles oAn=1111, then 6 cycles oAn=1110 with oSeg=0011001 (digit "4").
  - 2 off, then 6 cycles oAn=1101 with oSeg=0110000 (digit "3").
  - 2 off, then 6 cycles oAn=1011 with oSeg=0100100 and oDp=0 (digit "2" with point).
  - 2 off, then 6 cycles oAn=0111 with oSeg=1111001 (digit "1").
- **Tearing.** Change iData to 16'h5678 while digit 1 is active → digits 2 and 3 still show 2 and 1. The next frame shows 8,7,6,5.
- **Leading-zero blanking.** iData=16'h0050, iLzb=1:
  - digits 3 and 2 → oSeg=1111111 (blanked zeros);
  - digit 1 → 0010010 ("5");
  - digit 0 → 1000000 ("0", never blanked).
  - iData=16'h0000 → only digit 0 shows 1000000.
- **Hex mode.** Rebuild with HEX_MODE=1, iData=16'hABCF:
  - digit 0 = 0001110 (F), digit 1 = 1000110 (C), digit 2 = 0000011 (b), digit 3 = 0001000 (A).
  - With HEX_MODE=0, the same data gives 1111111 on all four digits.
- **Reset mid-frame.** Assert iRst for 1 cycle during digit 2's active window:
  - next cycle oAn=1111;
  - after release, 2 off cycles, then digit 0 is active;
  - the snapshot reloads from the current iData.
